// File: rtl/regbridge.sv
// rtl/regbridge.sv - dual-host register bridge: mailboxes, status word, doorbells and IRQs
//
// Two independent register ports (A = HPS, B = NIOS) share one register file.
// Per-port word map, M = N_A2B + N_B2A:
//   0 .. N_A2B-1   A->B mailboxes (written by A, read-only to B)
//   N_A2B .. M-1   B->A mailboxes (written by B, read-only to A)
//   M              STATUS   read-only, zero-extended stat_in
//   M+1            DB_PEND  own pending doorbells, write 1 to clear
//   M+2            DB_RING  write 1 to set peer pending, read peer pending
//   M+3            IRQ_EN   own interrupt enables
//
// Ports:
//   clk, rst_n                     clock, synchronous active-low reset
//   a_/b_bus_enable, a_/b_rw       access request, 1 = read / 0 = write
//   a_/b_address, a_/b_write_data  word address and write data
//   a_/b_read_data, a_/b_acknowledge  registered response, one cycle
//   a_/b_irq                       registered level interrupts
//   stat_in                        live status bits
//   a2b_regs, b2a_regs             exported mailbox contents, word 0 in LSBs
//   a_/b_db_pend                   exported pending doorbells

module regbridge #(
    parameter int DATA_W = 32,
    parameter int N_A2B  = 2,
    parameter int N_B2A  = 2,
    parameter int N_STAT = 8,
    parameter int N_DB   = 4,
    parameter int AW     = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      a_bus_enable,
    input  logic                      a_rw,
    input  logic [AW-1:0]             a_address,
    input  logic [DATA_W-1:0]         a_write_data,
    output logic [DATA_W-1:0]         a_read_data,
    output logic                      a_acknowledge,
    output logic                      a_irq,
    input  logic                      b_bus_enable,
    input  logic                      b_rw,
    input  logic [AW-1:0]             b_address,
    input  logic [DATA_W-1:0]         b_write_data,
    output logic [DATA_W-1:0]         b_read_data,
    output logic                      b_acknowledge,
    output logic                      b_irq,
    input  logic [N_STAT-1:0]         stat_in,
    output logic [N_A2B*DATA_W-1:0]   a2b_regs,
    output logic [N_B2A*DATA_W-1:0]   b2a_regs,
    output logic [N_DB-1:0]           a_db_pend,
    output logic [N_DB-1:0]           b_db_pend
);

    localparam int M         = N_A2B + N_B2A;
    localparam int ADDR_STAT = M;
    localparam int ADDR_PEND = M + 1;
    localparam int ADDR_RING = M + 2;
    localparam int ADDR_IEN  = M + 3;

    logic [N_DB-1:0]   a_irq_en;
    logic [N_DB-1:0]   b_irq_en;
    logic [DATA_W-1:0] stat_ext;
    logic [DATA_W-1:0] a_rd_mux;
    logic [DATA_W-1:0] b_rd_mux;
    logic              a_acc, b_acc;
    logic              a_wr, b_wr;
    logic [N_DB-1:0]   a_clr, b_clr;
    logic [N_DB-1:0]   a_ring, b_ring;

    // A request arriving while acknowledge is high belongs to the access
    // just completed, so it is not sampled again.
    assign a_acc = a_bus_enable && !a_acknowledge;
    assign b_acc = b_bus_enable && !b_acknowledge;
    assign a_wr  = a_acc && !a_rw;
    assign b_wr  = b_acc && !b_rw;

    always_comb begin
        stat_ext = '0;
        stat_ext[N_STAT-1:0] = stat_in;
    end

    always_comb begin
        a_clr  = '0;
        b_clr  = '0;
        a_ring = '0;
        b_ring = '0;
        if (a_wr && int'(a_address) == ADDR_PEND) a_clr  = a_write_data[N_DB-1:0];
        if (b_wr && int'(b_address) == ADDR_PEND) b_clr  = b_write_data[N_DB-1:0];
        if (a_wr && int'(a_address) == ADDR_RING) a_ring = a_write_data[N_DB-1:0];
        if (b_wr && int'(b_address) == ADDR_RING) b_ring = b_write_data[N_DB-1:0];
    end

    // Shared read decode; reads see current register contents, so a reader
    // racing the owner's write in the same cycle gets the old value.
    function automatic logic [DATA_W-1:0] read_word(
        input logic [AW-1:0]           addr,
        input logic [N_A2B*DATA_W-1:0] a2b,
        input logic [N_B2A*DATA_W-1:0] b2a,
        input logic [DATA_W-1:0]       stat,
        input logic [N_DB-1:0]         own_pend,
        input logic [N_DB-1:0]         peer_pend,
        input logic [N_DB-1:0]         own_ien
    );
        logic [DATA_W-1:0] rd;
        int                a;
        rd = '0;
        a  = int'(addr);
        for (int i = 0; i < N_A2B; i++) begin
            if (a == i) rd = a2b[i*DATA_W +: DATA_W];
        end
        for (int j = 0; j < N_B2A; j++) begin
            if (a == N_A2B + j) rd = b2a[j*DATA_W +: DATA_W];
        end
        if (a == ADDR_STAT) rd = stat;
        if (a == ADDR_PEND) rd[N_DB-1:0] = own_pend;
        if (a == ADDR_RING) rd[N_DB-1:0] = peer_pend;
        if (a == ADDR_IEN)  rd[N_DB-1:0] = own_ien;
        return rd;
    endfunction

    always_comb begin
        a_rd_mux = read_word(a_address, a2b_regs, b2a_regs, stat_ext,
                             a_db_pend, b_db_pend, a_irq_en);
        b_rd_mux = read_word(b_address, a2b_regs, b2a_regs, stat_ext,
                             b_db_pend, a_db_pend, b_irq_en);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_acknowledge <= 1'b0;
            b_acknowledge <= 1'b0;
            a_read_data   <= '0;
            b_read_data   <= '0;
        end else begin
            a_acknowledge <= a_acc;
            b_acknowledge <= b_acc;
            a_read_data   <= (a_acc && a_rw) ? a_rd_mux : '0;
            b_read_data   <= (b_acc && b_rw) ? b_rd_mux : '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a2b_regs <= '0;
            b2a_regs <= '0;
            a_irq_en <= '0;
            b_irq_en <= '0;
        end else begin
            for (int i = 0; i < N_A2B; i++) begin
                if (a_wr && int'(a_address) == i)
                    a2b_regs[i*DATA_W +: DATA_W] <= a_write_data;
            end
            for (int j = 0; j < N_B2A; j++) begin
                if (b_wr && int'(b_address) == N_A2B + j)
                    b2a_regs[j*DATA_W +: DATA_W] <= b_write_data;
            end
            if (a_wr && int'(a_address) == ADDR_IEN) a_irq_en <= a_write_data[N_DB-1:0];
            if (b_wr && int'(b_address) == ADDR_IEN) b_irq_en <= b_write_data[N_DB-1:0];
        end
    end

    // Ring is OR-ed in after the clear so a same-cycle ring keeps the bit set.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_db_pend <= '0;
            b_db_pend <= '0;
            a_irq     <= 1'b0;
            b_irq     <= 1'b0;
        end else begin
            a_db_pend <= (a_db_pend & ~a_clr) | b_ring;
            b_db_pend <= (b_db_pend & ~b_clr) | a_ring;
            a_irq     <= |(a_db_pend & a_irq_en);
            b_irq     <= |(b_db_pend & b_irq_en);
        end
    end

endmodule

// File: tb/tb_regbridge.sv
// tb/tb_regbridge.sv - directed vector bench for regbridge

module tb_regbridge;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        a_bus_enable, b_bus_enable;
    logic        a_rw, b_rw;
    logic [3:0]  a_address, b_address;
    logic [31:0] a_write_data, b_write_data;
    logic [31:0] a_read_data, b_read_data;
    logic        a_acknowledge, b_acknowledge;
    logic        a_irq, b_irq;
    logic [7:0]  stat_in;
    logic [63:0] a2b_regs, b2a_regs;
    logic [3:0]  a_db_pend, b_db_pend;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    regbridge dut (
        .clk(clk), .rst_n(rst_n),
        .a_bus_enable(a_bus_enable), .a_rw(a_rw), .a_address(a_address),
        .a_write_data(a_write_data), .a_read_data(a_read_data),
        .a_acknowledge(a_acknowledge), .a_irq(a_irq),
        .b_bus_enable(b_bus_enable), .b_rw(b_rw), .b_address(b_address),
        .b_write_data(b_write_data), .b_read_data(b_read_data),
        .b_acknowledge(b_acknowledge), .b_irq(b_irq),
        .stat_in(stat_in), .a2b_regs(a2b_regs), .b2a_regs(b2a_regs),
        .a_db_pend(a_db_pend), .b_db_pend(b_db_pend)
    );

    typedef struct {
        bit          port;   // 0 = A, 1 = B
        bit          rw;     // 1 = read
        logic [3:0]  addr;
        logic [31:0] wdata;
        logic [31:0] exp;    // expected read_data at acknowledge (0 for writes)
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic add(input bit port, input bit rw, input logic [3:0] addr,
                       input logic [31:0] wdata, input logic [31:0] exp);
        vec_t v;
        v.port = port; v.rw = rw; v.addr = addr; v.wdata = wdata; v.exp = exp;
        vecs.push_back(v);
    endtask

    // One access: enable driven for one sampling edge, response checked at the
    // following negedge, then checked to last only one cycle.
    task automatic access(input bit port, input bit rw, input logic [3:0] addr,
                          input logic [31:0] wdata, input logic [31:0] exp, input string name);
        @(negedge clk);
        if (port == 1'b0) begin
            a_bus_enable = 1'b1; a_rw = rw; a_address = addr; a_write_data = wdata;
        end else begin
            b_bus_enable = 1'b1; b_rw = rw; b_address = addr; b_write_data = wdata;
        end
        check({name, " ack_before"}, port ? b_acknowledge : a_acknowledge, 0);
        @(negedge clk);
        check({name, " ack"}, port ? b_acknowledge : a_acknowledge, 1);
        check({name, " data"}, port ? b_read_data : a_read_data, exp);
        a_bus_enable = 1'b0;
        b_bus_enable = 1'b0;
        @(negedge clk);
        check({name, " ack_after"}, port ? b_acknowledge : a_acknowledge, 0);
        check({name, " data_after"}, port ? b_read_data : a_read_data, 0);
    endtask

    initial begin
        int acks;
        rst_n = 1'b0;
        a_bus_enable = 0; a_rw = 0; a_address = 0; a_write_data = 0;
        b_bus_enable = 0; b_rw = 0; b_address = 0; b_write_data = 0;
        stat_in = 8'hA5;

        // Map for defaults: 0,1 A2B; 2,3 B2A; 4 STATUS; 5 PEND; 6 RING; 7 IEN
        for (int i = 0; i < 16; i++) add(0, 1, 4'(i), 0, (i == 4) ? 32'hA5 : 32'h0);
        add(0, 0, 4'd0, 32'hDEADBEEF, 0);
        add(1, 0, 4'd0, 32'h12345678, 0);
        add(1, 1, 4'd0, 0, 32'hDEADBEEF);
        add(0, 1, 4'd0, 0, 32'hDEADBEEF);
        add(0, 0, 4'd1, 32'h000000AB, 0);
        add(1, 1, 4'd1, 0, 32'h000000AB);
        add(1, 0, 4'd2, 32'hCAFEF00D, 0);
        add(0, 0, 4'd2, 32'h11111111, 0);
        add(0, 1, 4'd2, 0, 32'hCAFEF00D);
        add(1, 1, 4'd2, 0, 32'hCAFEF00D);
        add(1, 1, 4'd4, 0, 32'hA5);
        add(0, 0, 4'd9, 32'hFFFFFFFF, 0);
        add(0, 1, 4'd9, 0, 0);
        add(1, 0, 4'd7, 32'hFFFFFFFF, 0);
        add(1, 1, 4'd7, 0, 32'hF);
        add(1, 0, 4'd7, 32'h0, 0);

        repeat (2) @(negedge clk);
        check("rst ack_a", a_acknowledge, 0);
        check("rst ack_b", b_acknowledge, 0);
        check("rst rdata_a", a_read_data, 0);
        check("rst a2b", a2b_regs, 0);
        check("rst b2a", b2a_regs, 0);
        check("rst pend", {a_db_pend, b_db_pend}, 0);
        check("rst irq", {a_irq, b_irq}, 0);
        rst_n = 1'b1;

        foreach (vecs[k])
            access(vecs[k].port, vecs[k].rw, vecs[k].addr, vecs[k].wdata, vecs[k].exp,
                   $sformatf("vec%0d", k));

        check("export a2b", a2b_regs, 64'h000000AB_DEADBEEF);
        check("export b2a", b2a_regs, 64'h00000000_CAFEF00D);

        // Doorbell B -> A with IRQ timing
        access(0, 0, 4'd7, 32'h1, 0, "a ien");
        @(negedge clk);
        b_bus_enable = 1; b_rw = 0; b_address = 4'd6; b_write_data = 32'h5;
        @(negedge clk);
        b_bus_enable = 0;
        check("ring pend", a_db_pend, 4'h5);
        check("ring irq early", a_irq, 0);
        @(negedge clk);
        check("ring irq", a_irq, 1);
        access(1, 1, 4'd6, 0, 32'h5, "b read ring");
        access(0, 1, 4'd5, 0, 32'h5, "a read pend");
        @(negedge clk);
        a_bus_enable = 1; a_rw = 0; a_address = 4'd5; a_write_data = 32'h1;
        @(negedge clk);
        a_bus_enable = 0;
        check("clr pend", a_db_pend, 4'h4);
        @(negedge clk);
        check("clr irq", a_irq, 0);

        // Ring and clear of the same bit in the same cycle
        @(negedge clk);
        a_bus_enable = 1; a_rw = 0; a_address = 4'd5; a_write_data = 32'h4;
        b_bus_enable = 1; b_rw = 0; b_address = 4'd6; b_write_data = 32'h4;
        @(negedge clk);
        a_bus_enable = 0; b_bus_enable = 0;
        check("ring wins pend", a_db_pend, 4'h4);
        check("both ack", {a_acknowledge, b_acknowledge}, 2'b11);

        // A -> B doorbell, B irq disabled
        access(0, 0, 4'd6, 32'h3, 0, "a ring");
        check("b pend", b_db_pend, 4'h3);
        check("b irq off", b_irq, 0);
        access(1, 1, 4'd5, 0, 32'h3, "b read pend");

        // Held read: six sampling edges give three acknowledges
        @(negedge clk);
        a_bus_enable = 1; a_rw = 1; a_address = 4'd4;
        acks = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            check($sformatf("held ack%0d", c), a_acknowledge, (c % 2 == 0) ? 1 : 0);
            check($sformatf("held data%0d", c), a_read_data, (c % 2 == 0) ? 32'hA5 : 32'h0);
            if (a_acknowledge) acks++;
        end
        a_bus_enable = 0;
        check("held ack count", acks, 3);

        // Reset on the edge that would sample a write
        @(negedge clk);
        a_bus_enable = 1; a_rw = 0; a_address = 4'd1; a_write_data = 32'h55;
        rst_n = 0;
        @(negedge clk);
        a_bus_enable = 0;
        check("rst mid ack", a_acknowledge, 0);
        check("rst mid a2b", a2b_regs, 0);
        check("rst mid pend", {a_db_pend, b_db_pend}, 0);
        check("rst mid irq", {a_irq, b_irq}, 0);
        rst_n = 1;
        @(negedge clk);
        check("rst mid ack later", a_acknowledge, 0);
        access(1, 1, 4'd1, 0, 0, "post rst read");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/regbridge.md
# regbridge

Parametrised dual-host register bridge between the HPS (port A) and NIOS (port B) register slaves. Generalises the fixed four-register pair into configurable one-way mailboxes, a live status word readable by both hosts, and N independent doorbell bits per direction with per-bit set/clear, IRQ enables and a registered interrupt per host. It sits beside the video path; mailbox contents and doorbell state are also exported to fabric logic.

## Interface
- DATA_W, 32, register data width
- N_A2B, 2, mailbox words written by A, read-only to B
- N_B2A, 2, mailbox words written by B, read-only to A
- N_STAT, 8, live status input bits, must be <= DATA_W
- N_DB, 4, doorbell bits per direction, must be <= DATA_W
- AW, 4, word address width; 2^AW >= N_A2B+N_B2A+4

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous, active-low reset
- a_bus_enable / b_bus_enable  in  1  access request
- a_rw / b_rw  in  1  1 = read, 0 = write
- a_address / b_address  in  AW  word address
- a_write_data / b_write_data  in  DATA_W  write data
- a_read_data / b_read_data  out  DATA_W  read data, valid with acknowledge
- a_acknowledge / b_acknowledge  out  1  one-cycle access completion
- a_irq / b_irq  out  1  level interrupt to host
- stat_in  in  N_STAT  live status bits (already synchronous to clk)
- a2b_regs  out  N_A2B*DATA_W  A-owned mailboxes, word 0 in LSBs
- b2a_regs  out  N_B2A*DATA_W  B-owned mailboxes
- a_db_pend / b_db_pend  out  N_DB  doorbells pending at A / at B

## Operation
- Per-port map (identical for A and B); M = N_A2B+N_B2A:
  - 0..N_A2B-1: A→B mailboxes; RW from A, RO from B
  - N_A2B..M-1: B→A mailboxes; RW from B, RO from A
  - M: STATUS, RO, {0, stat_in}
  - M+1: DB_PEND, read own pending bits; write 1 per bit to clear
  - M+2: DB_RING, write 1 per bit to set the peer's pending bit; read returns peer pending bits (unacknowledged rings)
  - M+3: IRQ_EN, RW, low N_DB bits used
- Writes to RO registers and to unmapped addresses: acknowledged, no effect. Reads of unmapped addresses return 0. Unused upper bits read 0.
- Doorbells: a_db_pend set by B ring, cleared by A DB_PEND write; b_db_pend symmetric.
- a_irq = |(a_db_pend & a_irq_en), registered; b_irq likewise.
- Simultaneous events, same bit, same cycle: ring (set) wins over clear; pending stays 1.
- Same-cycle write by owner and read by other host of the same mailbox: reader gets the old value.
- Ports A and B are fully independent; both may complete an access in the same cycle.

## Timing
- Access sampled on a cycle with bus_enable=1 and acknowledge currently 0; acknowledge and read_data registered, asserted exactly one cycle later for one cycle.
- bus_enable seen during the acknowledge cycle is ignored (no double access); a held request therefore completes every second cycle.
- read_data is 0 in every cycle acknowledge is 0.
- Written register value visible on exported outputs and to reads one cycle after the write is sampled.
- Doorbell ring/clear updates *_db_pend one cycle after sampling; irq follows one further cycle (2 cycles ring→irq).
- Reset (rst_n=0 on a clk edge): all mailboxes, pending bits, IRQ enables, irq, acknowledge, read_data = 0. Reset mid-access drops the access, no acknowledge issued.

## Test plan
- Reset, then A reads every address 0..2^AW-1 -> all return 0 except STATUS = stat_in; one ack per access, exactly one cycle after enable.
- A writes 0xDEADBEEF to addr 0, B writes 0x12345678 to addr 0 -> B reads addr 0 = 0xDEADBEEF, a2b_regs[31:0] = 0xDEADBEEF.
- A sets IRQ_EN=0x1, B writes DB_RING=0x5 -> a_db_pend=0x5 next cycle, a_irq=1 two cycles after; B reads DB_RING=0x5; A writes DB_PEND=0x1 -> a_irq drops, a_db_pend=0x4.
- B rings bit 2 in the same cycle A clears bit 2 (pending=1) -> a_db_pend[2] remains 1.
- bus_enable held high for 6 cycles on a read -> exactly 3 acknowledges, alternating cycles.
- rst_n low during an accepted write cycle -> no acknowledge, target register stays 0.
